mini_src_control: RTL and testbench
===================================

Name: mini_src_control

Overview:
- Hardwired Moore control unit that sequences the Mini SRC DataPath through instruction fetch and execute.
- Replaces the hand-driven T0..Tn stimulus by decoding IR and driving the datapath enable/out/select/ALU controls every cycle.
- Supports ld, ldi, st, addi, andi, ori, nop and halt.
- Memory accesses use a ready handshake so wait states can be inserted.

Parameters:
- ALU_ADD, 5'b00011, alu_control code for addition.
- ALU_AND, 5'b00101, alu_control code for bitwise AND.
- ALU_OR, 5'b00110, alu_control code for bitwise OR.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-low reset.
- ir  in  32  IR register contents; opcode is ir[31:27].
- mem_rdy  in  1  memory completes the current Read/Write in this cycle.
- Pout, MARen, IncPC, Read, Write, MDRen, MDROut, IRen  out  1 each  PC/memory/IR controls.
- Gra, Grb, Rin, Rout, BAout  out  1 each  register-select logic controls.
- Yen, Cout, Zen, ZLOout  out  1 each  ALU path controls.
- alu_control  out  5  ALU operation code.
- run  out  1  high while executing; low in RESET and HALT.
- state  out  4  current state, for debug.

Behaviour:
- Outputs are a pure decode of the registered state. Any output not listed for a state is 0. alu_control is 0 unless stated.
- clr=0 at a rising edge: next state is RST, regardless of the current state, including mid-access.
- RST: all outputs 0, run=0. Next state is T0 once clr=1.
- run=1 in every state except RST and HALT.
- Opcodes: ld=00000, ldi=00001, st=00010, addi=01100, andi=01101, ori=01110, nop=11010, halt=11011. Any other opcode executes as nop.
- T0: Pout, MARen, IncPC → T1.
- T1: Read, MDRen. Stay in T1 while mem_rdy=0; go to T2 when mem_rdy=1.
- T2: MDROut, IRen → T3.
- T3 (decode is on ir, now valid):
  - nop or unknown opcode: no outputs → T0.
  - halt: → HALT.
  - otherwise: Grb, BAout, Yen → T4.
- T4: Cout, Zen. alu_control = ALU_ADD for ld/ldi/st/addi, ALU_AND for andi, ALU_OR for ori → T5.
- T5:
  - ld, st: ZLOout, MARen → T6.
  - ldi, addi, andi, ori: ZLOout, Gra, Rin → T0.
- T6:
  - ld: Read, MDRen; hold until mem_rdy=1 → T7.
  - st: Gra, Rout, MDRen (MDR loads from the bus) → T7.
- T7:
  - ld: MDROut, Gra, Rin → T0.
  - st: Write; hold until mem_rdy=1 → T0.
- HALT: all outputs 0, run=0. Stays until reset.
- mem_rdy is ignored outside T1, T6-ld and T7-st.
- Read and Write are never high together.
- Instruction latency with mem_rdy tied high:
  - nop: 4 cycles.
  - ldi/addi/andi/ori: 6 cycles.
  - ld/st: 8 cycles.
  - Each cycle of mem_rdy=0 in a wait state adds one cycle.
- Unused encodings of the 4-bit state register go to RST on the next edge.

Optional Feature:
- Macro INSTR_CNT_EN.
- When defined: adds output instr_cnt[31:0].
  - Resets to 0.
  - Increments by 1 on each transition into T0 from T3, T5 or T7 (an instruction retiring).
  - Wraps from 32'hFFFFFFFF to 0.
  - A halt instruction does not increment it.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- clr=0 for 2 cycles, then clr=1, mem_rdy=1, ir=ld (00000) → states RST,T0,T1,...,T7,T0. In T4 alu_control=5'b00011; in T7 MDROut=Gra=Rin=1; run=1 from T0 onward.
- ir=st, mem_rdy=0 for 3 cycles during T7 → Write stays high 4 cycles, then next state is T0; Read stays 0 throughout.
- ir=andi, then ir=ori, mem_rdy=1 → each takes 6 cycles; T4 alu_control is 5'b00101, then 5'b00110.
- ir opcode 11111 (unknown) → T0,T1,T2,T3,T0 with no Yen/Zen pulse; with INSTR_CNT_EN, instr_cnt goes 0→1.
- ir=halt → T3 then HALT with run=0; stays in HALT 10 cycles despite mem_rdy toggling; clr=0 for 1 cycle → RST, then T0.
- clr=0 while in T6 of ld with mem_rdy=0 → RST next cycle, Read=MDRen=0 and all outputs 0.

Source files
------------

// File: rtl/mini_src_control.sv
// rtl/mini_src_control.sv - Mini SRC hardwired Moore control unit (fetch/execute sequencer)
// Optional retired-instruction counter enabled by macro INSTR_CNT_EN.
module mini_src_control #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        Pout,
  output logic        MARen,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        MDRen,
  output logic        MDROut,
  output logic        IRen,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yen,
  output logic        Cout,
  output logic        Zen,
  output logic        ZLOout,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic [3:0]  state
`ifdef INSTR_CNT_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic       is_ld, is_st, is_mem, is_imm, is_exec, is_halt;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = (opcode == OP_LD);
  assign is_st     = (opcode == OP_ST);
  assign is_mem    = is_ld | is_st;
  assign is_imm    = (opcode == OP_LDI) | (opcode == OP_ADDI) |
                     (opcode == OP_ANDI) | (opcode == OP_ORI);
  assign is_exec   = is_mem | is_imm;
  assign is_halt   = (opcode == OP_HALT);

  always_comb begin
    state_d     = state_q;
    Pout        = 1'b0;
    MARen       = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    MDRen       = 1'b0;
    MDROut      = 1'b0;
    IRen        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Rin         = 1'b0;
    Rout        = 1'b0;
    BAout       = 1'b0;
    Yen         = 1'b0;
    Cout        = 1'b0;
    Zen         = 1'b0;
    ZLOout      = 1'b0;
    alu_control = 5'b00000;
    run         = 1'b1;
    case (state_q)
      S_RST: begin
        run     = 1'b0;
        state_d = S_T0;
      end
      S_T0: begin
        Pout    = 1'b1;
        MARen   = 1'b1;
        IncPC   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRen = 1'b1;
        if (mem_rdy) state_d = S_T2;
      end
      S_T2: begin
        MDROut  = 1'b1;
        IRen    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_exec) begin
          Grb     = 1'b1;
          BAout   = 1'b1;
          Yen     = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = S_T0;
        end
      end
      S_T4: begin
        Cout    = 1'b1;
        Zen     = 1'b1;
        state_d = S_T5;
        if (opcode == OP_ANDI)     alu_control = ALU_AND;
        else if (opcode == OP_ORI) alu_control = ALU_OR;
        else                       alu_control = ALU_ADD;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (is_mem) begin
          MARen   = 1'b1;
          state_d = S_T6;
        end else begin
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = S_T0;
        end
      end
      // Only ld/st reach T6/T7; anything that is not st follows the ld path.
      S_T6: begin
        MDRen = 1'b1;
        if (is_st) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          state_d = S_T7;
        end else begin
          Read = 1'b1;
          if (mem_rdy) state_d = S_T7;
        end
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
          if (mem_rdy) state_d = S_T0;
        end else begin
          MDROut  = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = S_T0;
        end
      end
      S_HALT: begin
        run = 1'b0;
      end
      default: begin
        run     = 1'b0;
        state_d = S_RST;
      end
    endcase
  end

  assign state = state_q;

`ifdef INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        retire;

  assign retire = (state_d == S_T0) &&
                  ((state_q == S_T3) || (state_q == S_T5) || (state_q == S_T7));

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + 32'd1;
  end

  assign instr_cnt = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_RST;
`ifdef INSTR_CNT_EN
      cnt_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef INSTR_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mini_src_control.sv
// tb/tb_mini_src_control.sv - scoreboard bench for mini_src_control
// Instruction-level model expands each instruction into its expected per-cycle control trace.
module tb_mini_src_control;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        mem_rdy = 1'b0;
  logic        Pout, MARen, IncPC, Read, Write, MDRen, MDROut, IRen;
  logic        Gra, Grb, Rin, Rout, BAout, Yen, Cout, Zen, ZLOout;
  logic [4:0]  alu_control;
  logic        run;
  logic [3:0]  state;
`ifdef INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  mini_src_control dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
    .Pout(Pout), .MARen(MARen), .IncPC(IncPC), .Read(Read), .Write(Write),
    .MDRen(MDRen), .MDROut(MDROut), .IRen(IRen),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yen(Yen), .Cout(Cout), .Zen(Zen), .ZLOout(ZLOout),
    .alu_control(alu_control), .run(run), .state(state)
`ifdef INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [3:0] RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
                         T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9;

  localparam logic [16:0] C_POUT = 17'h10000, C_MAREN = 17'h08000, C_INCPC = 17'h04000,
                          C_READ = 17'h02000, C_WRITE = 17'h01000, C_MDREN = 17'h00800,
                          C_MDROUT = 17'h00400, C_IREN = 17'h00200, C_GRA = 17'h00100,
                          C_GRB = 17'h00080, C_RIN = 17'h00040, C_ROUT = 17'h00020,
                          C_BAOUT = 17'h00010, C_YEN = 17'h00008, C_COUT = 17'h00004,
                          C_ZEN = 17'h00002, C_ZLOOUT = 17'h00001;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
                         OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  typedef struct packed {
    logic [3:0]  st;
    logic        run;
    logic [4:0]  alu;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic emit(input logic [3:0] st, input logic [16:0] ctl, input logic [4:0] alu,
                      input logic rdy, input logic clr_v, input logic [31:0] ir_v);
    exp_t e;
    @(posedge clk);
    #1;
    mem_rdy = rdy;
    clr     = clr_v;
    ir      = ir_v;
    e.st    = st;
    e.run   = (st != RST) && (st != HALT);
    e.alu   = alu;
    e.ctl   = ctl;
`ifdef INSTR_CNT_EN
    e.cnt   = exp_cnt;
`else
    e.cnt   = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Expands one instruction; abort6 pulls clr low in the first T6 cycle of an ld.
  task automatic issue(input logic [4:0] op, input int w1, input int w6, input int w7,
                       input bit abort6);
    logic [31:0] w;
    logic [4:0]  alu;
    w = {op, 27'($urandom)};
    emit(T0, C_POUT | C_MAREN | C_INCPC, 5'd0, rnd(), 1'b1, w);
    repeat (w1) emit(T1, C_READ | C_MDREN, 5'd0, 1'b0, 1'b1, w);
    emit(T1, C_READ | C_MDREN, 5'd0, 1'b1, 1'b1, w);
    emit(T2, C_MDROUT | C_IREN, 5'd0, rnd(), 1'b1, w);
    if (op == OP_HALT) begin
      emit(T3, 17'd0, 5'd0, rnd(), 1'b1, w);
      return;
    end
    if (!(op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI})) begin
      emit(T3, 17'd0, 5'd0, rnd(), 1'b1, w);
      exp_cnt++;
      return;
    end
    emit(T3, C_GRB | C_BAOUT | C_YEN, 5'd0, rnd(), 1'b1, w);
    alu = (op == OP_ANDI) ? 5'b00101 : (op == OP_ORI) ? 5'b00110 : 5'b00011;
    emit(T4, C_COUT | C_ZEN, alu, rnd(), 1'b1, w);
    if (op == OP_LD) begin
      emit(T5, C_ZLOOUT | C_MAREN, 5'd0, rnd(), 1'b1, w);
      if (abort6) begin
        emit(T6, C_READ | C_MDREN, 5'd0, 1'b0, 1'b0, w);
        exp_cnt = 32'd0;
        emit(RST, 17'd0, 5'd0, rnd(), 1'b1, w);
        return;
      end
      repeat (w6) emit(T6, C_READ | C_MDREN, 5'd0, 1'b0, 1'b1, w);
      emit(T6, C_READ | C_MDREN, 5'd0, 1'b1, 1'b1, w);
      emit(T7, C_MDROUT | C_GRA | C_RIN, 5'd0, rnd(), 1'b1, w);
    end else if (op == OP_ST) begin
      emit(T5, C_ZLOOUT | C_MAREN, 5'd0, rnd(), 1'b1, w);
      emit(T6, C_GRA | C_ROUT | C_MDREN, 5'd0, rnd(), 1'b1, w);
      repeat (w7) emit(T7, C_WRITE, 5'd0, 1'b0, 1'b1, w);
      emit(T7, C_WRITE, 5'd0, 1'b1, 1'b1, w);
    end else begin
      emit(T5, C_ZLOOUT | C_GRA | C_RIN, 5'd0, rnd(), 1'b1, w);
    end
    exp_cnt++;
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e, g;
      e = sb_q.pop_front();
      g.st  = state;
      g.run = run;
      g.alu = alu_control;
      g.ctl = {Pout, MARen, IncPC, Read, Write, MDRen, MDROut, IRen, Gra, Grb,
               Rin, Rout, BAout, Yen, Cout, Zen, ZLOout};
`ifdef INSTR_CNT_EN
      g.cnt = instr_cnt;
`else
      g.cnt = 32'd0;
`endif
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL cycle_trace t=%0t got st=%0d run=%b alu=%b ctl=%h cnt=%0d want st=%0d run=%b alu=%b ctl=%h cnt=%0d",
                 $time, g.st, g.run, g.alu, g.ctl, g.cnt, e.st, e.run, e.alu, e.ctl, e.cnt);
      end
      if (Read && Write) begin
        n_err++;
        $display("FAIL read_write_overlap t=%0t got Read=1 Write=1 want not both", $time);
      end
    end
  end

  initial begin
    logic [4:0] op;
    int         r;
    clr = 1'b0;
    emit(RST, 17'd0, 5'd0, 1'b1, 1'b0, 32'd0);
    emit(RST, 17'd0, 5'd0, 1'b1, 1'b1, 32'd0);

    issue(OP_LD, 0, 0, 0, 1'b0);
    issue(OP_ST, 0, 0, 3, 1'b0);
    issue(OP_ANDI, 0, 0, 0, 1'b0);
    issue(OP_ORI, 0, 0, 0, 1'b0);
    issue(5'b11111, 0, 0, 0, 1'b0);
    issue(OP_LDI, 2, 0, 0, 1'b0);
    issue(OP_ADDI, 0, 0, 0, 1'b0);
    issue(OP_NOP, 1, 0, 0, 1'b0);
    issue(OP_LD, 1, 2, 0, 1'b0);
    issue(OP_LD, 0, 0, 0, 1'b1);

    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: op = OP_LD;
        1: op = OP_LDI;
        2: op = OP_ST;
        3: op = OP_ADDI;
        4: op = OP_ANDI;
        5: op = OP_ORI;
        6: op = OP_NOP;
        default: op = 5'($urandom);
      endcase
      if (op == OP_HALT) op = OP_NOP;
      issue(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            (op == OP_LD) && ($urandom_range(0, 19) == 0));
    end

    issue(OP_HALT, 0, 0, 0, 1'b0);
    repeat (10) emit(HALT, 17'd0, 5'd0, rnd(), 1'b1, ir);
    emit(HALT, 17'd0, 5'd0, rnd(), 1'b0, ir);
    exp_cnt = 32'd0;
    emit(RST, 17'd0, 5'd0, rnd(), 1'b1, ir);
    issue(OP_ADDI, 0, 0, 0, 1'b0);
    emit(T0, C_POUT | C_MAREN | C_INCPC, 5'd0, 1'b1, 1'b1, ir);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
